// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard sources from the stage registers and the
// write-enable / flush controls fed back to them, plus performance counters.
interface pipe_hazard_ctrl_if;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_RegisterRt;
  logic [4:0]  IF_ID_RegisterRs;
  logic [4:0]  IF_ID_RegisterRt;
  logic        IF_ID_Halt;
  logic        BranchTaken;
  logic        EX_MEM_MemAccess;
  logic        DMemReady;

  logic        PCWrite;
  logic        IF_ID_Write;
  logic        ID_EX_Write;
  logic        EX_MEM_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Bubble;
  logic        EX_MEM_Bubble;
  logic        MEM_WB_Bubble;
  logic        Halted;
  logic        Fault;
  logic [31:0] StallCount;
  logic [31:0] FlushCount;

  modport master (
    input  ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
           IF_ID_Halt, BranchTaken, EX_MEM_MemAccess, DMemReady,
    output PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
           IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble, MEM_WB_Bubble,
           Halted, Fault, StallCount, FlushCount
  );

  modport slave (
    output ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
           IF_ID_Halt, BranchTaken, EX_MEM_MemAccess, DMemReady,
    input  PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
           IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble, MEM_WB_Bubble,
           Halted, Fault, StallCount, FlushCount
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage MIPS pipeline (Mealy FSM).
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic CLK,
  input logic RST,
  pipe_hazard_ctrl_if.master hz
);

  localparam int TW = $clog2(MEM_TIMEOUT + 2);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALTED   = 3'd3,
    FAULT    = 3'd4
  } stateE;

  stateE         state, nextState;
  logic [TW-1:0] timeoutCnt, nextTimeout;
  logic [1:0]    drainCnt, nextDrain;

  logic memWait, loadUse;
  logic freeze, runPri, lockAll;
  logic pcWrite, ifIdWrite, idExWrite, exMemWrite;
  logic ifIdFlush, idExBubble, exMemBubble, memWbBubble;
  logic halted, fault;

  function automatic logic [TW-1:0] satIncTout(input logic [TW-1:0] v);
    return (v == {TW{1'b1}}) ? v : v + TW'(1);
  endfunction

  assign memWait = hz.EX_MEM_MemAccess & ~hz.DMemReady;
  assign loadUse = hz.ID_EX_MemRead && (hz.ID_EX_RegisterRt != 5'd0) &&
                   ((hz.ID_EX_RegisterRt == hz.IF_ID_RegisterRs) ||
                    (hz.ID_EX_RegisterRt == hz.IF_ID_RegisterRt));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= RUN;
      timeoutCnt <= '0;
      drainCnt   <= '0;
    end else begin
      state      <= nextState;
      timeoutCnt <= nextTimeout;
      drainCnt   <= nextDrain;
    end
  end

  always_comb begin
    nextState   = state;
    nextTimeout = timeoutCnt;
    nextDrain   = drainCnt;
    case (state)
      RUN: begin
        if (memWait) begin
          nextState   = MEM_WAIT;
          nextTimeout = TW'(1);
        end else if (!hz.BranchTaken && hz.IF_ID_Halt) begin
          nextState = DRAIN;
          nextDrain = 2'd3;
        end
      end
      MEM_WAIT: begin
        if (!hz.DMemReady) begin
          nextTimeout = satIncTout(timeoutCnt);
          if ((MEM_TIMEOUT != 0) && (timeoutCnt == TW'(MEM_TIMEOUT)))
            nextState = FAULT;
        end else if (!hz.BranchTaken && hz.IF_ID_Halt) begin
          nextState = DRAIN;
          nextDrain = 2'd3;
        end else begin
          nextState = RUN;
        end
      end
      DRAIN: begin
        // A memory stall freezes the drain too, so the count only moves on live cycles.
        if (!memWait) begin
          nextDrain = drainCnt - 2'd1;
          if (drainCnt == 2'd1)
            nextState = HALTED;
        end
      end
      HALTED, FAULT: nextState = state;
      default: nextState = RUN;
    endcase
  end

  always_comb begin
    pcWrite     = 1'b1;
    ifIdWrite   = 1'b1;
    idExWrite   = 1'b1;
    exMemWrite  = 1'b1;
    ifIdFlush   = 1'b0;
    idExBubble  = 1'b0;
    exMemBubble = 1'b0;
    memWbBubble = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    freeze      = 1'b0;
    runPri      = 1'b0;
    lockAll     = 1'b0;

    if (RST) begin
      lockAll = 1'b1;
    end else begin
      case (state)
        RUN:      if (memWait) freeze = 1'b1; else runPri = 1'b1;
        MEM_WAIT: if (!hz.DMemReady) freeze = 1'b1; else runPri = 1'b1;
        DRAIN: begin
          if (memWait) begin
            freeze = 1'b1;
          end else begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
            // Squash the younger instructions but keep PC frozen: the core is halting.
            if (hz.BranchTaken) begin
              ifIdFlush   = 1'b1;
              exMemBubble = 1'b1;
            end
          end
        end
        HALTED: begin
          lockAll = 1'b1;
          halted  = 1'b1;
        end
        FAULT: begin
          lockAll = 1'b1;
          fault   = 1'b1;
        end
        default: lockAll = 1'b1;
      endcase
    end

    if (lockAll) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      idExWrite   = 1'b0;
      exMemWrite  = 1'b0;
      ifIdFlush   = 1'b1;
      idExBubble  = 1'b1;
      exMemBubble = 1'b1;
      memWbBubble = 1'b1;
    end

    if (freeze) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      idExWrite   = 1'b0;
      exMemWrite  = 1'b0;
      memWbBubble = 1'b1;
    end

    // Branch outranks halt and load-use: both belong to instructions being squashed.
    if (runPri) begin
      if (hz.BranchTaken) begin
        ifIdFlush   = 1'b1;
        idExBubble  = 1'b1;
        exMemBubble = 1'b1;
      end else if (hz.IF_ID_Halt || loadUse) begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        idExBubble = 1'b1;
      end
    end
  end

  assign hz.PCWrite       = pcWrite;
  assign hz.IF_ID_Write   = ifIdWrite;
  assign hz.ID_EX_Write   = idExWrite;
  assign hz.EX_MEM_Write  = exMemWrite;
  assign hz.IF_ID_Flush   = ifIdFlush;
  assign hz.ID_EX_Bubble  = idExBubble;
  assign hz.EX_MEM_Bubble = exMemBubble;
  assign hz.MEM_WB_Bubble = memWbBubble;
  assign hz.Halted        = halted;
  assign hz.Fault         = fault;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stallCount, flushCount;
  logic        liveState;

  function automatic logic [31:0] satInc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign liveState = (state == RUN) || (state == MEM_WAIT) || (state == DRAIN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (liveState && (!pcWrite || !ifIdWrite))
        stallCount <= satInc32(stallCount);
      if (liveState && ifIdFlush)
        flushCount <= satInc32(flushCount);
    end
  end

  assign hz.StallCount = stallCount;
  assign hz.FlushCount = flushCount;
`else
  assign hz.StallCount = 32'd0;
  assign hz.FlushCount = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl: one vector per clock, Mealy
// outputs checked mid-cycle, performance counters tracked from expected outputs.
module tb_pipe_hazard_ctrl;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl_if hzIf();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16)) dut (
    .CLK(CLK),
    .RST(RST),
    .hz (hzIf)
  );

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  // Write enables packed {PC, IF_ID, ID_EX, EX_MEM}; flush packed {IF_ID_Flush, ID_EX, EX_MEM, MEM_WB}.
  localparam logic [3:0] W_ALL   = 4'b1111;
  localparam logic [3:0] W_NONE  = 4'b0000;
  localparam logic [3:0] W_STALL = 4'b0011;
  localparam logic [3:0] F_NONE  = 4'b0000;
  localparam logic [3:0] F_ALL   = 4'b1111;
  localparam logic [3:0] F_BR    = 4'b1110;
  localparam logic [3:0] F_IDEX  = 4'b0100;
  localparam logic [3:0] F_MEMWB = 4'b0001;

  typedef struct {
    string      name;
    logic       rst;
    logic       memRead;
    logic [4:0] exRt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       halt;
    logic       br;
    logic       memAcc;
    logic       ready;
    logic [3:0] expW;
    logic [3:0] expF;
    logic       expH;
    logic       expFlt;
  } vecT;

  vecT         vecs[$];
  int          nRun  = 0;
  int          nFail = 0;
  int unsigned expStall = 0;
  int unsigned expFlush = 0;

  function automatic vecT mkv(input string name, input logic rst, input logic memRead,
                              input logic [4:0] exRt, input logic [4:0] rs, input logic [4:0] rt,
                              input logic halt, input logic br, input logic memAcc,
                              input logic ready, input logic [3:0] w, input logic [3:0] f,
                              input logic h, input logic flt);
    vecT v;
    v.name = name; v.rst = rst; v.memRead = memRead; v.exRt = exRt; v.rs = rs; v.rt = rt;
    v.halt = halt; v.br = br; v.memAcc = memAcc; v.ready = ready;
    v.expW = w; v.expF = f; v.expH = h; v.expFlt = flt;
    return v;
  endfunction

  task automatic addv(input vecT v);
    vecs.push_back(v);
  endtask

  task automatic check1(input string what, input logic [31:0] act, input logic [31:0] exp);
    nRun++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", what, act, exp);
    end
  endtask

  // Drive just after a rising edge, check on the falling edge, then advance one clock.
  task automatic apply(input vecT v);
    RST                   = v.rst;
    hzIf.ID_EX_MemRead    = v.memRead;
    hzIf.ID_EX_RegisterRt = v.exRt;
    hzIf.IF_ID_RegisterRs = v.rs;
    hzIf.IF_ID_RegisterRt = v.rt;
    hzIf.IF_ID_Halt       = v.halt;
    hzIf.BranchTaken      = v.br;
    hzIf.EX_MEM_MemAccess = v.memAcc;
    hzIf.DMemReady        = v.ready;
    if (v.rst) begin
      expStall = 0;
      expFlush = 0;
    end
    @(negedge CLK);
    check1({v.name, " writes"}, {28'd0, hzIf.PCWrite, hzIf.IF_ID_Write, hzIf.ID_EX_Write,
                                 hzIf.EX_MEM_Write}, {28'd0, v.expW});
    check1({v.name, " flush"}, {28'd0, hzIf.IF_ID_Flush, hzIf.ID_EX_Bubble, hzIf.EX_MEM_Bubble,
                                hzIf.MEM_WB_Bubble}, {28'd0, v.expF});
    check1({v.name, " halted"}, {31'd0, hzIf.Halted}, {31'd0, v.expH});
    check1({v.name, " fault"}, {31'd0, hzIf.Fault}, {31'd0, v.expFlt});
    check1({v.name, " stallcnt"}, hzIf.StallCount, PERF_ON ? expStall : 32'd0);
    check1({v.name, " flushcnt"}, hzIf.FlushCount, PERF_ON ? expFlush : 32'd0);
    if (!v.rst && !v.expH && !v.expFlt) begin
      if (!v.expW[3] || !v.expW[2]) expStall++;
      if (v.expF[3]) expFlush++;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Main table: reset, load-use, branch priority, memory wait, halt drain.
    addv(mkv("reset0",     1, 0, 0, 0, 0, 0, 0, 0, 0, W_NONE,  F_ALL,   0, 0));
    addv(mkv("reset1",     1, 1, 5, 5, 0, 1, 1, 1, 0, W_NONE,  F_ALL,   0, 0));
    addv(mkv("run_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,   F_NONE,  0, 0));
    addv(mkv("lu_rs",      0, 1, 5, 5, 0, 0, 0, 0, 0, W_STALL, F_IDEX,  0, 0));
    addv(mkv("lu_clear",   0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,   F_NONE,  0, 0));
    addv(mkv("lu_rt",      0, 1, 7, 3, 7, 0, 0, 0, 0, W_STALL, F_IDEX,  0, 0));
    addv(mkv("lu_r0",      0, 1, 0, 0, 0, 0, 0, 0, 0, W_ALL,   F_NONE,  0, 0));
    addv(mkv("lu_nomatch", 0, 1, 5, 6, 4, 0, 0, 0, 0, W_ALL,   F_NONE,  0, 0));
    addv(mkv("lu_noread",  0, 0, 5, 5, 5, 0, 0, 0, 0, W_ALL,   F_NONE,  0, 0));
    addv(mkv("br_prio",    0, 1, 5, 5, 0, 1, 1, 0, 0, W_ALL,   F_BR,    0, 0));
    addv(mkv("br_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,   F_NONE,  0, 0));
    addv(mkv("mw_enter",   0, 0, 0, 0, 0, 0, 1, 1, 0, W_NONE,  F_MEMWB, 0, 0));
    addv(mkv("mw_wait2",   0, 0, 0, 0, 0, 0, 0, 1, 0, W_NONE,  F_MEMWB, 0, 0));
    addv(mkv("mw_wait3",   0, 0, 0, 0, 0, 0, 0, 1, 0, W_NONE,  F_MEMWB, 0, 0));
    addv(mkv("mw_wait4",   0, 0, 0, 0, 0, 0, 0, 1, 0, W_NONE,  F_MEMWB, 0, 0));
    addv(mkv("mw_release", 0, 0, 0, 0, 0, 0, 0, 1, 1, W_ALL,   F_NONE,  0, 0));
    addv(mkv("mw_run",     0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,   F_NONE,  0, 0));
    addv(mkv("mw2_enter",  0, 0, 0, 0, 0, 0, 0, 1, 0, W_NONE,  F_MEMWB, 0, 0));
    addv(mkv("mw2_rel_lu", 0, 1, 9, 9, 0, 0, 0, 1, 1, W_STALL, F_IDEX,  0, 0));
    addv(mkv("mw2_run",    0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,   F_NONE,  0, 0));
    addv(mkv("halt_enter", 0, 0, 0, 0, 0, 1, 0, 0, 0, W_STALL, F_IDEX,  0, 0));
    addv(mkv("drain1",     0, 0, 0, 0, 0, 0, 0, 0, 0, W_STALL, F_IDEX,  0, 0));
    addv(mkv("drain_mw1",  0, 0, 0, 0, 0, 0, 0, 1, 0, W_NONE,  F_MEMWB, 0, 0));
    addv(mkv("drain_mw2",  0, 0, 0, 0, 0, 0, 0, 1, 0, W_NONE,  F_MEMWB, 0, 0));
    addv(mkv("drain_br",   0, 0, 0, 0, 0, 0, 1, 0, 0, W_STALL, F_BR,    0, 0));
    addv(mkv("drain3",     0, 0, 0, 0, 0, 0, 0, 0, 0, W_STALL, F_IDEX,  0, 0));
    addv(mkv("halted1",    0, 1, 5, 5, 0, 1, 1, 1, 0, W_NONE,  F_ALL,   1, 0));
    addv(mkv("halted2",    0, 0, 0, 0, 0, 0, 0, 0, 1, W_NONE,  F_ALL,   1, 0));
    addv(mkv("halt_rst",   1, 0, 0, 0, 0, 0, 0, 0, 0, W_NONE,  F_ALL,   0, 0));
    addv(mkv("post_rst",   0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,   F_NONE,  0, 0));

    RST = 1'b1;
    hzIf.ID_EX_MemRead = 0; hzIf.ID_EX_RegisterRt = 0; hzIf.IF_ID_RegisterRs = 0;
    hzIf.IF_ID_RegisterRt = 0; hzIf.IF_ID_Halt = 0; hzIf.BranchTaken = 0;
    hzIf.EX_MEM_MemAccess = 0; hzIf.DMemReady = 0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i]);

    // Timeout: one RUN freeze cycle plus 16 MEM_WAIT cycles, then FAULT until reset.
    apply(mkv("to_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, W_NONE, F_ALL, 0, 0));
    for (int i = 0; i < 17; i++)
      apply(mkv($sformatf("to_wait%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, 0, W_NONE, F_MEMWB, 0, 0));
    apply(mkv("to_fault1", 0, 0, 0, 0, 0, 0, 0, 1, 0, W_NONE, F_ALL, 0, 1));
    apply(mkv("to_fault2", 0, 0, 0, 0, 0, 1, 1, 1, 1, W_NONE, F_ALL, 0, 1));
    apply(mkv("to_clear",  1, 0, 0, 0, 0, 0, 0, 0, 0, W_NONE, F_ALL, 0, 0));
    apply(mkv("to_run",    0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,  F_NONE, 0, 0));

    // Reset in the middle of MEM_WAIT returns straight to RUN.
    apply(mkv("rmw_enter", 0, 0, 0, 0, 0, 0, 0, 1, 0, W_NONE, F_MEMWB, 0, 0));
    apply(mkv("rmw_wait",  0, 0, 0, 0, 0, 0, 0, 1, 0, W_NONE, F_MEMWB, 0, 0));
    apply(mkv("rmw_rst",   1, 0, 0, 0, 0, 0, 0, 1, 0, W_NONE, F_ALL,   0, 0));
    apply(mkv("rmw_run",   0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,  F_NONE,  0, 0));

    // Reset in the middle of DRAIN abandons the drain.
    apply(mkv("rdr_halt",  0, 0, 0, 0, 0, 1, 0, 0, 0, W_STALL, F_IDEX, 0, 0));
    apply(mkv("rdr_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, W_STALL, F_IDEX, 0, 0));
    apply(mkv("rdr_rst",   1, 0, 0, 0, 0, 0, 0, 0, 0, W_NONE,  F_ALL,  0, 0));
    apply(mkv("rdr_run1",  0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,   F_NONE, 0, 0));
    apply(mkv("rdr_run2",  0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,   F_NONE, 0, 0));
    apply(mkv("rdr_run3",  0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,   F_NONE, 0, 0));
    apply(mkv("rdr_run4",  0, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL,   F_NONE, 0, 0));

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
